// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and the 640x480@60 default constants.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
        logic      h_pol;
        logic      v_pol;
    } vga_timing_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam logic        DEF_H_POL    = 1'b0;
    localparam logic        DEF_V_POL    = 1'b0;

    localparam vga_timing_t VGA_480P = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33},
        h_pol: 1'b0,
        v_pol: 1'b0
    };

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one VGA axis, with terminal-count and sync-range decode.
module vga_axis_counter #(
    parameter int unsigned W        = 10,
    parameter int unsigned TOTAL    = 800,
    parameter int unsigned RANGE_LO = 656,
    parameter int unsigned RANGE_HI = 751
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o,
    output logic         in_range_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] LO   = W'(RANGE_LO);
    localparam logic [W-1:0] HI   = W'(RANGE_HI);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign in_range_o = (cnt_q >= LO) && (cnt_q <= HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Define VGA_TIMING_REG_OUT_EN to register the position and
// decoded outputs one pixel step behind the counters; otherwise they decode combinationally.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CORDW    = 10,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        H_POL    = DEF_H_POL,
    parameter logic        V_POL    = DEF_V_POL,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               pix_en,
    output logic [CORDW-1:0]   sx,
    output logic [CORDW-1:0]   sy,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line,
    output logic               frame,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CORDW-1:0] H_ACT_C = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT_C = CORDW'(V_ACTIVE);

    if (CORDW == 0 || FRAME_W == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
        H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
        $error("vga_timing_gen: timing and width parameters must be non-zero");
    end
    if ((H_TOTAL - 1) > ((2 ** CORDW) - 1) || (V_TOTAL - 1) > ((2 ** CORDW) - 1)) begin : g_cordw
        $error("vga_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CORDW-1:0] h_cnt, v_cnt;
    logic             h_tc, v_tc, h_rng, v_rng;

    vga_axis_counter #(
        .W        (CORDW),
        .TOTAL    (H_TOTAL),
        .RANGE_LO (H_ACTIVE + H_FP),
        .RANGE_HI (H_ACTIVE + H_FP + H_SYNC - 1)
    ) u_h_cnt (
        .clk_i      (clk_pix),
        .rst_i      (rst_pix),
        .en_i       (pix_en),
        .cnt_o      (h_cnt),
        .tc_o       (h_tc),
        .in_range_o (h_rng)
    );

    vga_axis_counter #(
        .W        (CORDW),
        .TOTAL    (V_TOTAL),
        .RANGE_LO (V_ACTIVE + V_FP),
        .RANGE_HI (V_ACTIVE + V_FP + V_SYNC - 1)
    ) u_v_cnt (
        .clk_i      (clk_pix),
        .rst_i      (rst_pix),
        .en_i       (pix_en & h_tc),
        .cnt_o      (v_cnt),
        .tc_o       (v_tc),
        .in_range_o (v_rng)
    );

    logic [FRAME_W-1:0] frame_cnt_q;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            frame_cnt_q <= '0;
        end else if (pix_en && h_tc && v_tc) begin
            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;

    logic hsync_d, vsync_d, de_d, line_d, frame_d;

    assign hsync_d = h_rng ? H_POL : ~H_POL;
    assign vsync_d = v_rng ? V_POL : ~V_POL;
    assign de_d    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign line_d  = pix_en && (h_cnt == '0);
    assign frame_d = line_d && (v_cnt == '0);

`ifdef VGA_TIMING_REG_OUT_EN
    logic [CORDW-1:0] sx_q, sy_q;
    logic             hsync_q, vsync_q, de_q, line_q, frame_q;

    // Loaded only on pixel steps so every output stays aligned to the same counter sample.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx_q    <= '0;
            sy_q    <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else if (pix_en) begin
            sx_q    <= h_cnt;
            sy_q    <= v_cnt;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign sx    = sx_q;
    assign sy    = sy_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign line  = line_q;
    assign frame = frame_q;
`else
    assign sx    = h_cnt;
    assign sy    = v_cnt;
    assign hsync = hsync_d;
    assign vsync = vsync_d;
    assign de    = de_d;
    assign line  = line_d;
    assign frame = frame_d;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 480p instance plus a tiny-timing instance, both checked
// every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
        int fw;
    } cfg_t;

    typedef struct {
        int sx, sy;
        bit hs, vs, de, ln, fr;
    } out_t;

`ifdef VGA_TIMING_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst, pix_en;
    always #5 clk = ~clk;

    logic [9:0]  d_sx, d_sy;
    logic        d_hs, d_vs, d_de, d_ln, d_fr;
    logic [15:0] d_fc;
    logic [2:0]  s_sx, s_sy;
    logic        s_hs, s_vs, s_de, s_ln, s_fr;
    logic [1:0]  s_fc;

    vga_timing_gen u_dut_def (
        .clk_pix   (clk),
        .rst_pix   (rst),
        .pix_en    (pix_en),
        .sx        (d_sx),
        .sy        (d_sy),
        .hsync     (d_hs),
        .vsync     (d_vs),
        .de        (d_de),
        .line      (d_ln),
        .frame     (d_fr),
        .frame_cnt (d_fc)
    );

    vga_timing_gen #(
        .CORDW(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0), .FRAME_W(2)
    ) u_dut_small (
        .clk_pix   (clk),
        .rst_pix   (rst),
        .pix_en    (pix_en),
        .sx        (s_sx),
        .sy        (s_sy),
        .hsync     (s_hs),
        .vsync     (s_vs),
        .de        (s_de),
        .line      (s_ln),
        .frame     (s_fr),
        .frame_cnt (s_fc)
    );

    cfg_t cfg [2];
    int   m_sx [2];
    int   m_sy [2];
    int   m_fc [2];
    out_t m_reg [2];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic out_t decode(input cfg_t c, input int x, input int y, input bit en);
        out_t o;
        o.sx = x;
        o.sy = y;
        o.hs = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
        o.vs = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : !c.vp;
        o.de = (x < c.ha) && (y < c.va);
        o.ln = en && (x == 0);
        o.fr = en && (x == 0) && (y == 0);
        return o;
    endfunction

    function automatic out_t reset_out(input cfg_t c);
        out_t o;
        o.sx = 0; o.sy = 0; o.hs = !c.hp; o.vs = !c.vp;
        o.de = 1'b0; o.ln = 1'b0; o.fr = 1'b0;
        return o;
    endfunction

    function automatic out_t expected(input int i);
`ifdef VGA_TIMING_REG_OUT_EN
        return m_reg[i];
`else
        return decode(cfg[i], m_sx[i], m_sy[i], pix_en);
`endif
    endfunction

    task automatic model_step(input int i);
        int ht, vt;
        ht = cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
        vt = cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
        if (rst) begin
            m_sx[i] = 0; m_sy[i] = 0; m_fc[i] = 0;
            m_reg[i] = reset_out(cfg[i]);
        end else if (pix_en) begin
            m_reg[i] = decode(cfg[i], m_sx[i], m_sy[i], 1'b1);
            m_sx[i]++;
            if (m_sx[i] == ht) begin
                m_sx[i] = 0;
                m_sy[i]++;
                if (m_sy[i] == vt) begin
                    m_sy[i] = 0;
                    m_fc[i] = (m_fc[i] + 1) % (1 << cfg[i].fw);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        out_t e;
        e = expected(0);
        check("def.sx", 32'(d_sx), e.sx);
        check("def.sy", 32'(d_sy), e.sy);
        check("def.hsync", 32'(d_hs), 32'(e.hs));
        check("def.vsync", 32'(d_vs), 32'(e.vs));
        check("def.de", 32'(d_de), 32'(e.de));
        check("def.line", 32'(d_ln), 32'(e.ln));
        check("def.frame", 32'(d_fr), 32'(e.fr));
        check("def.frame_cnt", 32'(d_fc), m_fc[0]);
        e = expected(1);
        check("small.sx", 32'(s_sx), e.sx);
        check("small.sy", 32'(s_sy), e.sy);
        check("small.hsync", 32'(s_hs), 32'(e.hs));
        check("small.vsync", 32'(s_vs), 32'(e.vs));
        check("small.de", 32'(s_de), 32'(e.de));
        check("small.line", 32'(s_ln), 32'(e.ln));
        check("small.frame", 32'(s_fr), 32'(e.fr));
        check("small.frame_cnt", 32'(s_fc), m_fc[1]);
    endtask

    // Model advances on the edge using the inputs held since the previous step.
    task automatic step(input bit r, input bit pe);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        rst    = r;
        pix_en = pe;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int last_fr_cyc, prev_fr, n_per;
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16};
        cfg[1] = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0, 2};
        for (int i = 0; i < 2; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_fc[i] = 0;
            m_reg[i] = reset_out(cfg[i]);
        end
        rst    = 1'b1;
        pix_en = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);

        check("pin.rst_sx", 32'(d_sx), 0);
        check("pin.rst_hsync", 32'(d_hs), 1);
        check("pin.rst_de", 32'(d_de), LAT ? 0 : 1);
        check("pin.rst_line", 32'(d_ln), LAT ? 0 : 1);
        check("pin.rst_fc", 32'(s_fc), 0);

        for (int k = 1; k <= 1700; k++) begin
            step(1'b0, 1'b1);
            if (k == 655 + LAT) check("pin.hs655", 32'(d_hs), 1);
            if (k == 656 + LAT) check("pin.hs656", 32'(d_hs), 0);
            if (k == 751 + LAT) check("pin.hs751", 32'(d_hs), 0);
            if (k == 752 + LAT) check("pin.hs752", 32'(d_hs), 1);
            if (k == 639 + LAT) check("pin.de639", 32'(d_de), 1);
            if (k == 640 + LAT) check("pin.de640", 32'(d_de), 0);
            if (k == 799 + LAT) check("pin.sx799", 32'(d_sx), 799);
            if (k == 800 + LAT) begin
                check("pin.sx_wrap", 32'(d_sx), 0);
                check("pin.sy_step", 32'(d_sy), 1);
            end
            if (k == 4 + LAT) check("pin.s_hs4", 32'(s_hs), 0);
            if (k == 5 + LAT) check("pin.s_hs5", 32'(s_hs), 1);
            if (k == 6 + LAT) check("pin.s_hs6", 32'(s_hs), 0);
            if (k == 35) check("pin.s_fc35", 32'(s_fc), 1);
            if (k == 35 + LAT) check("pin.s_frame35", 32'(s_fr), 1);
            if (k == 105) check("pin.s_fc105", 32'(s_fc), 3);
            if (k == 140) check("pin.s_fc_wrap", 32'(s_fc), 0);
        end

        for (int k = 0; k < 6000; k++) begin
            step(($urandom_range(0, 49) == 0), 1'(($urandom_range(0, 1))));
        end

        // Mid-frame reset with pix_en held high: reset must win.
        for (int k = 0; k < 300; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("pin.mid_rst_sx", 32'(d_sx), 0);
        check("pin.mid_rst_sy", 32'(d_sy), 0);
        check("pin.mid_rst_fc", 32'(d_fc), 0);
        check("pin.mid_rst_sfc", 32'(s_fc), 0);

        // Alternating enable: tiny frame of 35 steps spans 70 clocks.
        last_fr_cyc = -1;
        prev_fr     = 0;
        n_per       = 0;
        for (int k = 0; k < 3000; k++) begin
            step(1'b0, 1'(k % 2));
            if (s_fr && !prev_fr) begin
                if (last_fr_cyc >= 0 && n_per < 10) begin
                    check("alt.frame_period", k - last_fr_cyc, 70);
                    n_per++;
                end
                last_fr_cyc = k;
            end
            prev_fr = int'(s_fr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
